// File: rtl/preg_release_queue.sv
// preg_release_queue
//   Sits on the commit side of the physical-register freelist. Each cycle it
//   accepts up to two committed instructions from the ROB and buffers the old
//   (superseded) physical destination index of every one that needs freeing.
//   It then drains the buffer in commit order onto the freelist's two write
//   ports. The buffer absorbs freelist stalls, so no register is lost.
//
// Ports
//   clock, reset               rising-edge clock, async active-high reset
//   commit{0,1}_valid          commit slot valid (slot 0 is the older one)
//   commit{0,1}_need_free      the slot supersedes a preg that must be freed
//   commit{0,1}_old_preg       index of the superseded preg
//   commit_ready               room for two releases this cycle (registered)
//   free_stall                 the freelist refuses writes this cycle
//   free{0,1}_valid/_preg      freelist write ports; port 0 carries the oldest entry
//   occupancy                  entries currently buffered
//   overflow_err               sticky; a push was attempted while !commit_ready
//
// Configuration
//   PREG_RELEASE_BYPASS_EN     When this macro is defined, an empty or nearly
//                              empty, unstalled buffer forwards pushes straight
//                              to the free ports in the same cycle.
module preg_release_queue #(
  parameter int PREG_IDX_WIDTH = 6,
  parameter int DEPTH          = 8,
  parameter int LOG_DEPTH      = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      commit0_valid,
  input  logic                      commit0_need_free,
  input  logic [PREG_IDX_WIDTH-1:0] commit0_old_preg,
  input  logic                      commit1_valid,
  input  logic                      commit1_need_free,
  input  logic [PREG_IDX_WIDTH-1:0] commit1_old_preg,
  output logic                      commit_ready,
  input  logic                      free_stall,
  output logic                      free0_valid,
  output logic [PREG_IDX_WIDTH-1:0] free0_preg,
  output logic                      free1_valid,
  output logic [PREG_IDX_WIDTH-1:0] free1_preg,
  output logic [LOG_DEPTH:0]        occupancy,
  output logic                      overflow_err
);

  // Two free slots are needed, so the buffer is ready while count <= DEPTH-2.
  localparam logic [LOG_DEPTH:0] READY_MAX = (LOG_DEPTH+1)'(DEPTH - 2);
  localparam logic [LOG_DEPTH:0] CNT_TWO   = (LOG_DEPTH+1)'(2);

  logic [LOG_DEPTH:0]        rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]        wr_ptr_q, wr_ptr_d;
  logic                      overflow_q, overflow_d;
  logic [PREG_IDX_WIDTH-1:0] mem_q [DEPTH];

  logic [LOG_DEPTH:0]        count;
  logic [LOG_DEPTH-1:0]      rd_idx0, rd_idx1, wr_idx0, wr_idx1;
  logic                      push0, push1, any_push;
  logic [1:0]                n_push, n_rd, n_wr;
  logic [PREG_IDX_WIDTH-1:0] first_preg, second_preg;
  logic [PREG_IDX_WIDTH-1:0] wr_data0, wr_data1;

  // The wrap bit distinguishes full from empty, so a plain subtraction gives the count.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign occupancy    = count;
  assign commit_ready = (count <= READY_MAX);
  assign overflow_err = overflow_q;

  assign rd_idx0 = rd_ptr_q[LOG_DEPTH-1:0];
  assign rd_idx1 = rd_ptr_q[LOG_DEPTH-1:0] + LOG_DEPTH'(1);
  assign wr_idx0 = wr_ptr_q[LOG_DEPTH-1:0];
  assign wr_idx1 = wr_ptr_q[LOG_DEPTH-1:0] + LOG_DEPTH'(1);

  assign push0    = commit0_valid & commit0_need_free;
  assign push1    = commit1_valid & commit1_need_free;
  assign any_push = push0 | push1;

  // Compact the pushes: when slot 0 has nothing to free, slot 1 becomes the first push.
  assign first_preg  = push0 ? commit0_old_preg : commit1_old_preg;
  assign second_preg = commit1_old_preg;

  // Pushes made while not ready are dropped entirely.
  always_comb begin
    n_push = 2'd0;
    if (commit_ready) begin
      n_push = {1'b0, push0} + {1'b0, push1};
    end
  end

  always_comb begin
    free0_valid = 1'b0;
    free0_preg  = '0;
    free1_valid = 1'b0;
    free1_preg  = '0;
    n_rd        = 2'd0;
    n_wr        = n_push;
    wr_data0    = first_preg;
    wr_data1    = second_preg;

    if (!free_stall) begin
      if (count != '0) begin
        free0_valid = 1'b1;
        free0_preg  = mem_q[rd_idx0];
        n_rd        = 2'd1;
      end
      if (count >= CNT_TWO) begin
        free1_valid = 1'b1;
        free1_preg  = mem_q[rd_idx1];
        n_rd        = 2'd2;
      end
    end

`ifdef PREG_RELEASE_BYPASS_EN
    // Forward only into free port slots that the buffer leaves empty. This keeps
    // every bypassed entry younger than every stored entry it overtakes.
    if (!free_stall && (n_push != 2'd0)) begin
      if (count == '0) begin
        free0_valid = 1'b1;
        free0_preg  = first_preg;
        if (n_push == 2'd2) begin
          free1_valid = 1'b1;
          free1_preg  = second_preg;
        end
        n_wr = 2'd0;
      end else if (count == (LOG_DEPTH+1)'(1)) begin
        // Port 1 takes the oldest push; any second push is stored behind it.
        free1_valid = 1'b1;
        free1_preg  = first_preg;
        n_wr        = n_push - 2'd1;
        wr_data0    = second_preg;
      end
    end
`endif
  end

  assign rd_ptr_d   = rd_ptr_q + (LOG_DEPTH+1)'(n_rd);
  assign wr_ptr_d   = wr_ptr_q + (LOG_DEPTH+1)'(n_wr);
  assign overflow_d = overflow_q | (any_push & ~commit_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers decide which entries are live.
  always_ff @(posedge clock) begin
    if (n_wr != 2'd0) begin
      mem_q[wr_idx0] <= wr_data0;
    end
    if (n_wr == 2'd2) begin
      mem_q[wr_idx1] <= wr_data1;
    end
  end

endmodule
